// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus signals of the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the datapath/cache plus RAM model that surrounds it.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction port
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [DW-1:0] iload;
    // data port
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dwait;
    logic [DW-1:0] dload;
    // RAM side
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between the instruction
// fetch and data access ports. Each access holds the RAM enables for LAT
// cycles, then acks the granted port for one cycle before re-arbitrating.
module mem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK}         state_t;
    typedef enum logic [1:0] {G_NONE, G_INSTR, G_DATA}  grant_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        r_state, w_state_nxt;
    grant_t        r_grant, w_grant_nxt;
    grant_t        r_last,  w_last_nxt;
    grant_t        w_pick;
    logic [3:0]    r_cnt,   w_cnt_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_store;
    logic          r_wr;
    logic [DW-1:0] r_iload, r_dload;
    logic          w_ireq, w_dreq, w_granted_req;
    logic          w_latch, w_capture;

    assign w_ireq = bus.iREN;
    assign w_dreq = bus.dREN | bus.dWEN;

    // Request of whichever port currently owns the RAM; dropping it aborts.
    always_comb begin
        w_granted_req = 1'b0;
        if (r_grant == G_INSTR)     w_granted_req = w_ireq;
        else if (r_grant == G_DATA) w_granted_req = w_dreq;
    end

    // Arbitration: single requester wins outright, a tie goes to the port
    // that did not win the previous completed access.
    always_comb begin
        w_pick = G_NONE;
        if (w_ireq && w_dreq)  w_pick = (r_last == G_INSTR) ? G_DATA : G_INSTR;
        else if (w_dreq)       w_pick = G_DATA;
        else if (w_ireq)       w_pick = G_INSTR;
    end

    // Next-state logic for the IDLE -> ACCESS -> ACK sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick != G_NONE) begin
                    w_state_nxt = ACCESS;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = CNT_INIT;
                    w_latch     = 1'b1;
                end
            end
            ACCESS: begin
                if (!w_granted_req) begin
                    // abort: no ack, no capture, last untouched
                    w_state_nxt = IDLE;
                    w_grant_nxt = G_NONE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_capture   = ~r_wr;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_last_nxt  = r_grant;
                w_grant_nxt = G_NONE;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = G_NONE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_grant <= G_NONE;
            r_last  <= G_INSTR;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch the winner's address/data at grant so later bus changes are ignored.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr  <= '0;
            r_store <= '0;
            r_wr    <= 1'b0;
        end else if (w_latch) begin
            r_addr  <= (w_pick == G_DATA) ? bus.daddr : bus.iaddr;
            r_store <= (w_pick == G_DATA) ? bus.dstore : '0;
            r_wr    <= (w_pick == G_DATA) & bus.dWEN;
        end
    end

    // Load registers: updated only by a completed read of their own port.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_iload <= '0;
            r_dload <= '0;
        end else if (w_capture) begin
            if (r_grant == G_INSTR) r_iload <= bus.ramload;
            else                    r_dload <= bus.ramload;
        end
    end

    // RAM drive and stall outputs, decoded from registered state.
    always_comb begin
        bus.ramREN   = (r_state == ACCESS) & ~r_wr;
        bus.ramWEN   = (r_state == ACCESS) &  r_wr;
        bus.ramaddr  = (r_state == ACCESS) ? r_addr  : '0;
        bus.ramstore = (r_state == ACCESS) ? r_store : '0;
        bus.iwait    = w_ireq & ~((r_state == ACK) && (r_grant == G_INSTR));
        bus.dwait    = w_dreq & ~((r_state == ACK) && (r_grant == G_DATA));
        bus.iload    = r_iload;
        bus.dload    = r_dload;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LAT=2). Inputs change 1 unit after a rising
// edge, outputs are checked on the falling edge. Cycle 0 of each scenario is
// the cycle in which the request is first presented.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    // RAM model: fixed word at 0x40, otherwise address xor a marker.
    assign bus.ramload = (bus.ramaddr == 32'h40) ? 32'h8C01_0004
                                                 : (bus.ramaddr ^ 32'hA5A5_0000);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] ds);
        bus.iREN   = ir;
        bus.iaddr  = ia;
        bus.dREN   = dr;
        bus.dWEN   = dw;
        bus.daddr  = da;
        bus.dstore = ds;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #12;
        chk("rst_ramREN",   bus.ramREN,   0);
        chk("rst_ramWEN",   bus.ramWEN,   0);
        chk("rst_ramaddr",  bus.ramaddr,  0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_iload",    bus.iload,    0);
        chk("rst_dload",    bus.dload,    0);
        chk("rst_iwait",    bus.iwait,    0);
        chk("rst_dwait",    bus.dwait,    0);
        tick;
        nRST = 1'b1;
        tick;

        // ---- single instruction read
        for (int c = 0; c <= 5; c++) begin
            if (c <= 3) drive(1, 32'h40, 0, 0, 0, 0);
            else        drive(0, 32'h40, 0, 0, 0, 0);
            @(negedge CLK);
            chk($sformatf("i1_ramREN_c%0d", c), bus.ramREN, (c == 1 || c == 2));
            chk($sformatf("i1_iwait_c%0d", c),  bus.iwait,  (c <= 2));
            if (c == 1) chk("i1_ramaddr", bus.ramaddr, 32'h40);
            if (c == 3) chk("i1_iload",   bus.iload,   32'h8C01_0004);
            tick;
        end

        // ---- both ports held: D, I, D, I with acks 4 cycles apart
        for (int c = 0; c <= 16; c++) begin
            if (c <= 15) drive(1, 32'h40, 1, 0, 32'h200, 0);
            else         drive(0, 32'h40, 0, 0, 32'h200, 0);
            @(negedge CLK);
            if (c <= 15) begin
                chk($sformatf("rr_dwait_c%0d", c), bus.dwait, !(c == 3 || c == 11));
                chk($sformatf("rr_iwait_c%0d", c), bus.iwait, !(c == 7 || c == 15));
            end
            if (c == 1) chk("rr_addr_d", bus.ramaddr, 32'h200);
            if (c == 5) chk("rr_addr_i", bus.ramaddr, 32'h40);
            if (c == 3) chk("rr_dload",  bus.dload,   32'hA5A5_0200);
            if (c == 16) chk("rr_idle_ramREN", bus.ramREN, 0);
            tick;
        end

        // ---- data write; address changed mid-access must be ignored
        for (int c = 0; c <= 4; c++) begin
            if (c == 0)      drive(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF);
            else if (c <= 3) drive(0, 0, 1, 1, 32'h300, 32'h1234_5678);
            else             drive(0, 0, 0, 0, 32'h300, 32'h1234_5678);
            @(negedge CLK);
            chk($sformatf("wr_ramWEN_c%0d", c), bus.ramWEN, (c == 1 || c == 2));
            chk($sformatf("wr_ramREN_c%0d", c), bus.ramREN, 0);
            chk($sformatf("wr_dwait_c%0d", c),  bus.dwait,  (c <= 2));
            if (c == 1 || c == 2) begin
                chk($sformatf("wr_addr_c%0d", c),  bus.ramaddr,  32'h100);
                chk($sformatf("wr_store_c%0d", c), bus.ramstore, 32'hDEAD_BEEF);
            end
            if (c == 3) chk("wr_dload_kept", bus.dload, 32'hA5A5_0200);
            tick;
        end

        // ---- data read aborted in first ACCESS cycle, pending iREN served next
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) drive(0, 32'h40, 1, 0, 32'h500, 0);
            else        drive(1, 32'h40, 0, 0, 32'h500, 0);
            @(negedge CLK);
            chk($sformatf("ab_dwait_c%0d", c), bus.dwait, (c == 0));
            chk($sformatf("ab_ramREN_c%0d", c), bus.ramREN, (c == 1 || c == 3 || c == 4));
            if (c == 2) chk("ab_ramWEN", bus.ramWEN, 0);
            if (c >= 1) chk($sformatf("ab_iwait_c%0d", c), bus.iwait, (c != 5));
            if (c == 3) chk("ab_addr_i", bus.ramaddr, 32'h40);
            tick;
        end
        chk("ab_dload_kept", bus.dload, 32'hA5A5_0200);

        // ---- async reset mid instruction access, then restart with held iREN
        drive(1, 32'h80, 0, 0, 0, 0);       // granted this cycle (IDLE)
        tick;                                // now in ACCESS
        @(negedge CLK);
        chk("rs_pre_ramREN", bus.ramREN, 1);
        chk("rs_pre_iload",  bus.iload,  32'h8C01_0004);
        nRST = 1'b0;
        #1;
        chk("rs_ramREN",  bus.ramREN,  0);
        chk("rs_ramaddr", bus.ramaddr, 0);
        chk("rs_iload",   bus.iload,   0);
        chk("rs_dload",   bus.dload,   0);
        chk("rs_iwait",   bus.iwait,   1);
        #1;
        nRST = 1'b1;                         // released before the next edge: cycle 0
        for (int c = 1; c <= 3; c++) begin
            tick;
            @(negedge CLK);
            chk($sformatf("rs_iwait_c%0d", c),  bus.iwait,  (c != 3));
            chk($sformatf("rs_ramREN_c%0d", c), bus.ramREN, (c <= 2));
        end
        chk("rs_iload_new", bus.iload, 32'hA5A5_0080);
        tick;
        drive(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch port and the data-access port of the datapath's cache interface.
- Sequences each RAM access through a fixed-latency handshake and returns load data to the granted requester.
- On a tie, grants the requester that did not win the previous access (round-robin), so neither port starves.
- Sits between the datapath/cache side and the RAM model.

Parameters:
- LAT, 2, RAM access latency in cycles; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  AW  instruction address.
- iwait  out  1  instruction port stall.
- iload  out  DW  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  AW  data address.
- dstore  in  DW  data write value.
- dwait  out  1  data port stall.
- dload  out  DW  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, cnt=0, grant=NONE, last=INSTR.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
  - iload=dload=0; data registers cleared.
  - Reset mid-access aborts it; no ack is ever issued for the aborted access.
- Request definitions: ireq=iREN; dreq=dREN|dWEN. If dREN and dWEN are both high, the access is a write.
- Wait outputs (combinational):
  - iwait = ireq & ~(state==ACK & grant==INSTR).
  - dwait = dreq & ~(state==ACK & grant==DATA).
  - With no request, wait=0.
- States:
  - IDLE
    - If exactly one request is pending, grant it.
    - If both are pending, grant the port != last.
    - On a grant: latch address, store data and write-type; cnt<=LAT-1; go to ACCESS.
    - No request: stay in IDLE.
  - ACCESS
    - ramaddr/ramstore come from the latched values.
    - ramREN=~wr, ramWEN=wr.
    - If cnt!=0: cnt<=cnt-1.
    - If cnt==0: for a read, capture ramload into the granted port's load register; go to ACK.
    - RAM enables are asserted for exactly LAT cycles.
  - ACK
    - Granted port's wait=0 for exactly 1 cycle.
    - RAM enables=0.
    - last<=grant; go to IDLE.
    - A new grant can be issued in the following IDLE cycle. Back-to-back throughput is one access per LAT+2 cycles.
- Latency: request seen in IDLE at cycle 0 -> RAM driven cycles 1..LAT -> wait low at cycle LAT+1.
- Abort: if the granted request drops while in ACCESS, return to IDLE on the next edge.
  - No ack; load register unchanged; last unchanged.
  - RAM enables fall on the same edge.
- Address or data changes mid-access are ignored, because the latched values are used.
- iload/dload hold their last captured value until overwritten by a later read of the same port.
- Writes never modify dload.
- cnt width is 4 bits; LAT=1 means cnt loads 0 and ACCESS lasts 1 cycle.

Test Plan:
- LAT=2, iREN=1, iaddr=0x40, RAM returns 0x8C010004:
  - ramREN high in cycles 1-2; iwait=1 in cycles 0-2, 0 in cycle 3.
  - iload=0x8C010004.
  - Deassert iREN in cycle 4; no further RAM activity.
- Simultaneous iREN and dREN after reset (last=INSTR):
  - Data is served first; dwait low in cycle 3.
  - Instruction is granted in cycle 4; iwait low in cycle 7.
- Both requests held continuously for 4 accesses:
  - Grants alternate D, I, D, I.
  - Each ack comes exactly 4 cycles after the previous one.
- dWEN=dREN=1, daddr=0x100, dstore=0xDEADBEEF:
  - ramWEN high for 2 cycles with ramaddr=0x100 and ramstore=0xDEADBEEF; ramREN stays 0.
  - dload is unchanged.
- dREN dropped in the first ACCESS cycle:
  - Next cycle is IDLE with RAM enables 0; no dwait pulse.
  - A pending iREN is granted immediately.
- nRST pulsed low mid-ACCESS of an instruction read:
  - All outputs return to reset values asynchronously.
  - After release, a held iREN restarts and completes in LAT+1 cycles.
